// File: rtl/bip_calc_pkg.sv
// bip_calc_pkg: shared SDH constants and helpers for BIP-8 generation and checking.
package bip_calc_pkg;
   localparam int BIP_W = 8;
   localparam int STM1_WORDS_8  = 2430;
   localparam int STM1_WORDS_16 = 1215;
   // 2430 bytes do not divide by four; the last 32-bit word carries two pad bytes
   localparam int STM1_WORDS_32 = 608;
   typedef logic [BIP_W-1:0] bip_t;
   function automatic logic [3:0] popcount8(input bip_t b);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < BIP_W; i++) c += 4'(b[i]);
      return c;
   endfunction
endpackage

// File: rtl/bip_calc_fold.sv
// bip_fold: XOR-folds every byte lane of a data word down to one BIP byte.
module bip_fold
   import bip_calc_pkg::*;
#(
   parameter int N_BYTES = 1
) (
   input  logic [8*N_BYTES-1:0] data_i,
   output bip_t                 fold_o
);
   always_comb begin
      fold_o = '0;
      for (int i = 0; i < N_BYTES; i++) fold_o ^= data_i[BIP_W*i +: BIP_W];
   end
endmodule

// File: rtl/bip_calc.sv
// bip_calc: per-frame BIP-8 generation with optional check against a received BIP byte.
module bip_calc
   import bip_calc_pkg::*;
#(
   parameter int N_BYTES     = 1,
   parameter int FRAME_WORDS = STM1_WORDS_8,
   parameter int CHK_WORD    = 0,
   parameter int CHK_LANE    = 0,
   parameter int CNT_W       = 16
) (
   input  logic                 sdh_clk,
   input  logic                 rst,
   input  logic [8*N_BYTES-1:0] data_in,
   input  logic                 data_vld,
   input  logic                 sof,
   input  logic                 mode,
   input  logic                 cnt_clr,
   output logic [7:0]           bip_out,
   output logic                 bip_out_vld,
   output logic                 bip_err,
   output logic [3:0]           err_bits,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 len_err
);
   localparam int IDX_W = $clog2(FRAME_WORDS + 2);

   bip_t             fold, acc_q, acc_d, bip_q, bip_d, cap_q, cap_d;
   logic [IDX_W-1:0] idx_q, idx_d, cur_idx;
   logic             seen_q, seen_d, ok_q, ok_d, vld_q, vld_d, len_q, len_d;
   logic             pend_q, pend_d, berr_q, berr_d;
   logic [3:0]       bits_q, bits_d, err;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
   logic [CNT_W:0]   sum;
   logic             sof_w, roll, short_frame, capture, cmp;

   bip_fold #(.N_BYTES(N_BYTES)) u_fold (.data_i(data_in), .fold_o(fold));

   always_comb begin
      sof_w       = sof & data_vld;
      roll        = sof_w & seen_q;
      short_frame = idx_q != IDX_W'(FRAME_WORDS - 1);
      cur_idx     = sof_w ? '0 : idx_q + IDX_W'(1);
      acc_d       = sof_w ? fold : data_vld ? acc_q ^ fold : acc_q;
      idx_d       = sof_w ? '0 : (data_vld && idx_q != IDX_W'(FRAME_WORDS)) ? idx_q + IDX_W'(1) : idx_q;
      seen_d      = seen_q | sof_w;
      ok_d        = roll ? !short_frame : ok_q;
      bip_d       = roll ? acc_q : bip_q;
      vld_d       = roll;
      len_d       = roll & short_frame;
      // mode is sampled only on the capture word, so a mid-frame change waits for the next one
      capture     = data_vld & mode & seen_d & (cur_idx == IDX_W'(CHK_WORD));
      cap_d       = capture ? data_in[8*CHK_LANE +: 8] : cap_q;
      pend_d      = capture;
      cmp         = pend_q & ok_q;
      err         = popcount8(cap_q ^ bip_q);
      sum         = {1'b0, cnt_q} + (CNT_W+1)'(err);
      cnt_sat     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      bits_d      = cmp ? err : bits_q;
      berr_d      = cmp & (err != '0);
      cnt_d       = cmp ? (cnt_clr ? CNT_W'(err) : cnt_sat) : cnt_clr ? '0 : cnt_q;
   end

   always_ff @(posedge sdh_clk) begin
      if (rst) begin
         acc_q  <= '0;
         idx_q  <= '0;
         seen_q <= 1'b0;
         ok_q   <= 1'b0;
         bip_q  <= '0;
         vld_q  <= 1'b0;
         len_q  <= 1'b0;
         cap_q  <= '0;
         pend_q <= 1'b0;
         bits_q <= '0;
         berr_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         idx_q  <= idx_d;
         seen_q <= seen_d;
         ok_q   <= ok_d;
         bip_q  <= bip_d;
         vld_q  <= vld_d;
         len_q  <= len_d;
         cap_q  <= cap_d;
         pend_q <= pend_d;
         bits_q <= bits_d;
         berr_q <= berr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bip_out     = bip_q;
   assign bip_out_vld = vld_q;
   assign len_err     = len_q;
   assign bip_err     = berr_q;
   assign err_bits    = bits_q;
   assign err_cnt     = cnt_q;
endmodule

// File: tb/tb_bip_calc.sv
// tb_bip_calc: directed and random frames against a frame-level BIP-8 reference model.
module tb_bip_calc;
   localparam int FW   = 4;
   localparam int NB   = 4;
   localparam int CW   = 4;
   localparam int CHKW = 0;

   logic          clk = 1'b0;
   logic          rst, data_vld, sof, mode, cnt_clr;
   logic [31:0]   data_in;
   logic [7:0]    bip_out;
   logic          bip_out_vld, bip_err, len_err;
   logic [3:0]    err_bits;
   logic [CW-1:0] err_cnt;

   always #5 clk = ~clk;

   bip_calc #(.N_BYTES(NB), .FRAME_WORDS(FW), .CHK_WORD(CHKW), .CHK_LANE(0), .CNT_W(CW)) dut (
      .sdh_clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld), .sof(sof), .mode(mode),
      .cnt_clr(cnt_clr), .bip_out(bip_out), .bip_out_vld(bip_out_vld), .bip_err(bip_err),
      .err_bits(err_bits), .err_cnt(err_cnt), .len_err(len_err));

   logic [31:0] frm[$];
   bit          have, ok, pend;
   logic [7:0]  pb, e_bip;
   bit          e_vld, e_len, e_berr;
   logic [3:0]  e_bits, e_cnt;
   int          vectors = 0, miss = 0;

   function automatic logic [7:0] fx();
      logic [7:0] x;
      x = '0;
      foreach (frm[i]) for (int b = 0; b < NB; b++) x ^= frm[i][8*b +: 8];
      return x;
   endfunction

   task automatic model(input logic [31:0] d, input bit v, s, m, c, r);
      int err, idx;
      if (r) begin
         frm.delete(); have = 0; ok = 0; pend = 0; pb = '0;
         e_bip = '0; e_vld = 0; e_len = 0; e_berr = 0; e_bits = '0; e_cnt = '0;
         return;
      end
      e_vld = 0; e_len = 0; e_berr = 0;
      if (pend && ok) begin
         err = $countones(pb ^ e_bip);
         e_bits = 4'(err);
         e_berr = err != 0;
         e_cnt = c ? 4'(err) : 4'((int'(e_cnt) + err > 15) ? 15 : int'(e_cnt) + err);
      end else if (c) e_cnt = '0;
      pend = 0;
      if (v) begin
         if (s) begin
            if (have) begin
               e_bip = fx(); e_vld = 1; e_len = frm.size() != FW; ok = !e_len;
            end
            frm.delete(); frm.push_back(d); have = 1;
         end else frm.push_back(d);
         idx = s ? 0 : frm.size() - 1;
         if (m && have && idx == CHKW) begin
            pend = 1; pb = d[7:0];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic cyc(input logic [31:0] d, input bit v, s, m, c, r);
      data_in = d; data_vld = v; sof = s; mode = m; cnt_clr = c; rst = r;
      model(d, v, s, m, c, r);
      @(posedge clk);
      #1;
      chk("bip_out", 32'(bip_out), 32'(e_bip));
      chk("bip_out_vld", 32'(bip_out_vld), 32'(e_vld));
      chk("len_err", 32'(len_err), 32'(e_len));
      chk("bip_err", 32'(bip_err), 32'(e_berr));
      chk("err_bits", 32'(err_bits), 32'(e_bits));
      chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
   endtask

   task automatic w(input logic [31:0] d, input bit s, m);
      cyc(d, 1, s, m, 0, 0);
   endtask

   int          fc, tgt;
   bit          v, s, m, c;
   logic [31:0] d;

   initial begin
      repeat (3) cyc(32'hDEADBEEF, 1, 1, 1, 1, 1);
      chk("rst_cnt", 32'(err_cnt), 32'h0);
      // first frame, closed by a second sof
      w(32'h1, 1, 0);
      chk("first_sof_vld", 32'(bip_out_vld), 32'h0);
      w(32'h2, 0, 0); w(32'h4, 0, 0); w(32'h8, 0, 0);
      w(32'h01020408, 1, 0);
      chk("fold_bip", 32'(bip_out), 32'h0F);
      chk("fold_vld", 32'(bip_out_vld), 32'h1);
      repeat (3) w(32'h01020408, 0, 0);
      w(32'h000000FF, 1, 0);
      chk("cancel_bip", 32'(bip_out), 32'h00);
      repeat (3) w(32'h0, 0, 0);
      w(32'h0000000F, 1, 0);
      chk("ff_bip", 32'(bip_out), 32'hFF);
      repeat (3) w(32'h0, 0, 0);
      // matching received byte, then an 8-bit error
      w(32'h0000000F, 1, 1);
      w(32'h0, 0, 1);
      chk("match_err", 32'(bip_err), 32'h0);
      w(32'h0, 0, 1); w(32'h0, 0, 1);
      w(32'h000000F0, 1, 1);
      chk("err_early", 32'(bip_err), 32'h0);
      w(32'h0, 0, 1);
      chk("err_pulse", 32'(bip_err), 32'h1);
      chk("err_bits8", 32'(err_bits), 32'h8);
      chk("err_cnt8", 32'(err_cnt), 32'h8);
      // short frame: three words only
      w(32'h0, 0, 1);
      w(32'h0, 1, 1);
      chk("len_err", 32'(len_err), 32'h1);
      w(32'h0, 0, 1);
      chk("skip_err", 32'(bip_err), 32'h0);
      chk("skip_cnt", 32'(err_cnt), 32'h8);
      w(32'h0, 0, 1); w(32'h0, 0, 1);
      // saturation, then clear with a simultaneous 3-bit error
      w(32'h000000FF, 1, 1);
      w(32'h0, 0, 1);
      chk("sat1", 32'(err_cnt), 32'hF);
      w(32'h0, 0, 1); w(32'h0, 0, 1);
      w(32'h0, 1, 1);
      w(32'h0, 0, 1);
      chk("sat2", 32'(err_cnt), 32'hF);
      w(32'h0, 0, 1); w(32'h0, 0, 1);
      w(32'h07, 1, 1);
      cyc(32'h0, 1, 0, 1, 1, 0);
      chk("clr_cmp", 32'(err_cnt), 32'h3);
      cyc(32'h0, 1, 0, 1, 1, 0);
      chk("clr_only", 32'(err_cnt), 32'h0);
      w(32'h0, 0, 1);
      // reset mid-frame
      w(32'h11, 1, 0); w(32'h22, 0, 0);
      repeat (2) cyc(32'h33, 1, 1, 1, 1, 1);
      chk("rst_bip", 32'(bip_out), 32'h0);
      chk("rst_bits", 32'(err_bits), 32'h0);
      w(32'h5, 1, 0);
      chk("post_rst_first", 32'(bip_out_vld), 32'h0);
      w(32'h0, 0, 0); w(32'h0, 0, 0); w(32'h0, 0, 0);
      cyc(32'hAA, 0, 1, 1, 0, 0);
      w(32'h9, 1, 0);
      chk("post_rst_second", 32'(bip_out_vld), 32'h1);
      chk("post_rst_bip", 32'(bip_out), 32'h05);
      // random traffic
      fc = 1; tgt = FW; m = 0;
      for (int i = 0; i < 800; i++) begin
         v = $urandom_range(0, 3) != 0;
         s = 0;
         d = $urandom;
         if ($urandom_range(0, 19) == 0) m = ~m;
         c = $urandom_range(0, 29) == 0;
         if (v && fc >= tgt) begin
            s = 1; fc = 1;
            tgt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 6)) : FW;
            if ($urandom_range(0, 2) == 0) d[7:0] = fx();
         end else if (v) fc++;
         else s = $urandom_range(0, 1) != 0;
         cyc(d, v, s, m, c, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end
endmodule
